// File: rtl/btd4_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : btd4_divider_seq
//  Description : Sequential balanced-ternary divider, 4-trit / 2-trit,
//                restoring binary core, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module btd4_divider_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       err_div0,
    output logic       err_ill
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_DIV    = 3'd2;
    localparam logic [2:0] c_ST_ENCODE = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    logic [2:0] r_state;
    logic [7:0] r_dvd_code;
    logic [3:0] r_dsr_code;
    logic [5:0] r_quo;
    logic [2:0] r_rem;
    logic [2:0] r_dsr_mag;
    logic [2:0] r_cnt;
    logic       r_sign_q;
    logic       r_sign_r;

    function automatic logic signed [2:0] trit_val(input logic [1:0] c);
        case (c)
            2'b10:   trit_val = 3'sd1;
            2'b01:   trit_val = -3'sd1;
            default: trit_val = 3'sd0;
        endcase
    endfunction

    function automatic logic [1:0] trit_enc(input logic signed [7:0] m);
        if (m == 8'sd1)       trit_enc = 2'b10;
        else if (m == -8'sd1) trit_enc = 2'b01;
        else                  trit_enc = 2'b11;
    endfunction

    // Balanced digit extraction: fold a truncated residue of +/-2 into -/+1.
    function automatic logic [7:0] to_bt4(input logic signed [7:0] v);
        logic signed [7:0] x;
        logic signed [7:0] m;
        logic [7:0]        code;
        x    = v;
        code = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            m = x % 8'sd3;
            if (m > 8'sd1)       m = m - 8'sd3;
            else if (m < -8'sd1) m = m + 8'sd3;
            code[2*i +: 2] = trit_enc(m);
            x = (x - m) / 8'sd3;
        end
        to_bt4 = code;
    endfunction

    function automatic logic [3:0] to_bt2(input logic signed [7:0] v);
        logic signed [7:0] x;
        logic signed [7:0] m;
        logic [3:0]        code;
        x    = v;
        code = 4'hF;
        for (int i = 0; i < 2; i++) begin
            m = x % 8'sd3;
            if (m > 8'sd1)       m = m - 8'sd3;
            else if (m < -8'sd1) m = m + 8'sd3;
            code[2*i +: 2] = trit_enc(m);
            x = (x - m) / 8'sd3;
        end
        to_bt2 = code;
    endfunction

    logic signed [6:0] w_dvd_val;
    logic signed [3:0] w_dsr_val;
    logic [5:0]        w_dvd_mag;
    logic [2:0]        w_dsr_mag;
    logic              w_ill;
    logic              w_dsr_zero;
    logic [3:0]        w_trial;
    logic              w_qbit;
    logic [2:0]        w_rem_next;
    logic signed [7:0] w_q_val;
    logic signed [7:0] w_r_val;

    assign w_dvd_val = 7'(27 * trit_val(r_dvd_code[7:6]) + 9 * trit_val(r_dvd_code[5:4])
                        + 3 * trit_val(r_dvd_code[3:2]) + trit_val(r_dvd_code[1:0]));
    assign w_dsr_val = 4'(3 * trit_val(r_dsr_code[3:2]) + trit_val(r_dsr_code[1:0]));
    assign w_dvd_mag = w_dvd_val[6] ? 6'(-w_dvd_val) : w_dvd_val[5:0];
    assign w_dsr_mag = w_dsr_val[3] ? 3'(-w_dsr_val) : w_dsr_val[2:0];

    assign w_ill = (r_dvd_code[7:6] == 2'b00) || (r_dvd_code[5:4] == 2'b00) ||
                   (r_dvd_code[3:2] == 2'b00) || (r_dvd_code[1:0] == 2'b00) ||
                   (r_dsr_code[3:2] == 2'b00) || (r_dsr_code[1:0] == 2'b00);
    assign w_dsr_zero = (w_dsr_val == 4'sd0);

    // One restoring step: remainder is always below the divisor (<= 3).
    assign w_trial    = {r_rem, r_quo[5]};
    assign w_qbit     = (w_trial >= {1'b0, r_dsr_mag});
    assign w_rem_next = w_qbit ? 3'(w_trial - {1'b0, r_dsr_mag}) : w_trial[2:0];

    assign w_q_val = r_sign_q ? -$signed({2'b00, r_quo}) : $signed({2'b00, r_quo});
    assign w_r_val = r_sign_r ? -$signed({5'b00000, r_rem}) : $signed({5'b00000, r_rem});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_dvd_code <= 8'hFF;
            r_dsr_code <= 4'hF;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dsr_mag  <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            quotient   <= 8'hFF;
            remainder  <= 4'hF;
            err_div0   <= 1'b0;
            err_ill    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_dvd_code <= dividend;
                        r_dsr_code <= divisor;
                        in_ready   <= 1'b0;
                        err_div0   <= 1'b0;
                        err_ill    <= 1'b0;
                        r_state    <= c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    r_quo     <= w_dvd_mag;
                    r_dsr_mag <= w_dsr_mag;
                    r_rem     <= '0;
                    r_sign_q  <= w_dvd_val[6] ^ w_dsr_val[3];
                    r_sign_r  <= w_dvd_val[6];
                    err_ill   <= w_ill;
                    err_div0  <= w_dsr_zero && !w_ill;
                    r_cnt     <= 3'd5;
                    r_state   <= c_ST_DIV;
                end
                c_ST_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[4:0], w_qbit};
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd0) r_state <= c_ST_ENCODE;
                end
                c_ST_ENCODE: begin
                    if (err_ill || err_div0) begin
                        quotient  <= 8'hFF;
                        remainder <= 4'hF;
                    end else begin
                        quotient  <= to_bt4(w_q_val);
                        remainder <= to_bt2(w_r_val);
                    end
                    out_valid <= 1'b1;
                    r_state   <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btd4_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btd4_divider_seq
//  Description : Directed self-checking bench for btd4_divider_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btd4_divider_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       err_div0;
    logic       err_ill;

    int n_assert = 0;
    int n_fail   = 0;

    btd4_divider_seq u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .err_div0  (err_div0),
        .err_ill   (err_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge while the DUT is idle.
    task automatic start_op(input logic [7:0] d, input logic [3:0] v);
        in_valid = 1'b1;
        dividend = d;
        divisor  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] d, input logic [3:0] v,
                          input logic [7:0] eq, input logic [3:0] er,
                          input logic eill, input logic ediv0);
        int lat;
        start_op(d, v);
        wait_result(lat);
        check({tag, "_lat"}, 8'(lat), 8'd8);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, {4'h0, remainder}, {4'h0, er});
        check({tag, "_ill"}, {7'd0, err_ill}, {7'd0, eill});
        check({tag, "_div0"}, {7'd0, err_div0}, {7'd0, ediv0});
        @(posedge clk);
        #1;
        check({tag, "_vld_clr"}, {7'd0, out_valid}, 8'd0);
        check({tag, "_rdy_set"}, {7'd0, in_ready}, 8'd1);
    endtask

    initial begin
        int   lat;
        logic seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 8'h00;
        divisor   = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_q", quotient, 8'hFF);
        check("rst_r", {4'h0, remainder}, 8'h0F);
        check("rst_err", {6'd0, err_ill, err_div0}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("16/-4", 8'h96, 4'h5, 8'hF5, 4'hF, 1'b0, 1'b0);
        run_op("12/-3", 8'hEB, 4'h7, 8'hF5, 4'hF, 1'b0, 1'b0);
        run_op("7/2",   8'hE6, 4'h9, 8'hFB, 4'hE, 1'b0, 1'b0);
        run_op("-7/2",  8'hD9, 4'h9, 8'hF7, 4'hD, 1'b0, 1'b0);
        run_op("-7/-2", 8'hD9, 4'h6, 8'hFB, 4'hD, 1'b0, 1'b0);
        run_op("40/-4", 8'hAA, 4'h5, 8'hDD, 4'hF, 1'b0, 1'b0);
        run_op("div0",  8'hE6, 4'hF, 8'hFF, 4'hF, 1'b0, 1'b1);

        // Error flags must drop at the accept of the following operation.
        start_op(8'h96, 4'h5);
        check("errclr_div0", {7'd0, err_div0}, 8'd0);
        wait_result(lat);
        check("errclr_lat", 8'(lat), 8'd8);
        check("errclr_q", quotient, 8'hF5);
        @(posedge clk);
        #1;

        run_op("ill", 8'h3F, 4'h9, 8'hFF, 4'hF, 1'b1, 1'b0);

        // Backpressure with a competing request held on the input.
        out_ready = 1'b0;
        start_op(8'hEB, 4'h7);
        wait_result(lat);
        check("bp_lat", 8'(lat), 8'd8);
        in_valid = 1'b1;
        dividend = 8'hE6;
        divisor  = 4'h9;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {7'd0, out_valid}, 8'd1);
            check("bp_hold_ready", {7'd0, in_ready}, 8'd0);
            check("bp_hold_q", quotient, 8'hF5);
            check("bp_hold_r", {4'h0, remainder}, 8'h0F);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {7'd0, out_valid}, 8'd0);
        check("bp_release_ready", {7'd0, in_ready}, 8'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accept", {7'd0, in_ready}, 8'd0);
        wait_result(lat);
        check("bp_second_lat", 8'(lat), 8'd8);
        check("bp_second_q", quotient, 8'hFB);
        check("bp_second_r", {4'h0, remainder}, 8'h0E);
        @(posedge clk);
        #1;

        run_op("-40/1", 8'h55, 4'hE, 8'h55, 4'hF, 1'b0, 1'b0);

        // Reset pulse while the divider is in its third DIV cycle.
        start_op(8'h96, 4'h5);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_q", quotient, 8'hFF);
        check("midrst_r", {4'h0, remainder}, 8'h0F);
        check("midrst_valid", {7'd0, out_valid}, 8'd0);
        check("midrst_ready", {7'd0, in_ready}, 8'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_partial", {7'd0, seen_valid}, 8'd0);
        run_op("post_rst", 8'hD9, 4'h9, 8'hF7, 4'hD, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
